// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: HI/LO multiply/divide unit.
// Runs MULT/MULTU with a fixed latency of MUL_STAGES edges and DIV/DIVU as a
// restoring divider that retires one quotient bit per cycle (WIDTH+1 edges).
// MTHI/MTLO write HI/LO straight from IDLE.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, op         request strobe and operation code (accepted only in IDLE)
//   src_a, src_b      rs / rt operands
//   flush             abort of the in-flight operation (also discards start)
//   busy              operation in flight
//   done              one-cycle completion pulse
//   div_by_zero       one-cycle pulse with done when the divisor was zero
//   hi, lo            HI and LO registers
module hilo_muldiv_unit #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned PROD_W = 2 * WIDTH;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DIV_RUN = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    // a_q: multiplicand, or dividend magnitude shifting into quotient bits
    // b_q: multiplier, or divisor magnitude
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] rem_q;
    logic             mul_signed_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             dbz_pend_q;

    // Operand magnitudes for the divider, taken at the accepting edge
    logic             div_signed_c;
    logic [WIDTH-1:0] abs_a_c;
    logic [WIDTH-1:0] abs_b_c;

    always_comb begin
        div_signed_c = (op == OP_DIV);
        abs_a_c      = (div_signed_c && src_a[WIDTH-1]) ? -src_a : src_a;
        abs_b_c      = (div_signed_c && src_b[WIDTH-1]) ? -src_b : src_b;
    end

    // Full product; sign-extending to 2*WIDTH makes the low half exact for both signednesses
    logic [PROD_W-1:0] ext_a_c;
    logic [PROD_W-1:0] ext_b_c;
    logic [PROD_W-1:0] product_c;

    always_comb begin
        ext_a_c   = {{WIDTH{mul_signed_q & a_q[WIDTH-1]}}, a_q};
        ext_b_c   = {{WIDTH{mul_signed_q & b_q[WIDTH-1]}}, b_q};
        product_c = ext_a_c * ext_b_c;
    end

    // One restoring-division step: shift in the next dividend bit, subtract if it fits
    logic [WIDTH:0]   trial_c;
    logic [WIDTH:0]   diff_c;
    logic             fits_c;
    logic [WIDTH-1:0] rem_next_c;

    always_comb begin
        trial_c    = {rem_q, a_q[WIDTH-1]};
        diff_c     = trial_c - {1'b0, b_q};
        fits_c     = (trial_c >= {1'b0, b_q});
        rem_next_c = fits_c ? diff_c[WIDTH-1:0] : trial_c[WIDTH-1:0];
    end

    // Sign restoration; most-negative / -1 wraps back to most-negative on its own
    logic [WIDTH-1:0] quo_fix_c;
    logic [WIDTH-1:0] rem_fix_c;

    always_comb begin
        quo_fix_c = neg_quo_q ? -a_q : a_q;
        rem_fix_c = neg_rem_q ? -rem_q : rem_q;
    end

    // Control FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            a_q          <= '0;
            b_q          <= '0;
            rem_q        <= '0;
            mul_signed_q <= 1'b0;
            neg_quo_q    <= 1'b0;
            neg_rem_q    <= 1'b0;
            dbz_pend_q   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            div_by_zero  <= 1'b0;
            hi           <= '0;
            lo           <= '0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                state        <= MUL_RUN;
                                busy         <= 1'b1;
                                cnt          <= CNT_W'(MUL_STAGES - 1);
                                a_q          <= src_a;
                                b_q          <= src_b;
                                mul_signed_q <= (op == OP_MULT);
                            end
                            OP_DIV, OP_DIVU: begin
                                state      <= DIV_RUN;
                                busy       <= 1'b1;
                                cnt        <= CNT_W'(WIDTH);
                                a_q        <= abs_a_c;
                                b_q        <= abs_b_c;
                                rem_q      <= '0;
                                neg_quo_q  <= div_signed_c & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                                neg_rem_q  <= div_signed_c & src_a[WIDTH-1];
                                dbz_pend_q <= (src_b == '0);
                            end
                            OP_MTHI: hi <= src_a;
                            OP_MTLO: lo <= src_a;
                            default: ;
                        endcase
                    end
                end

                MUL_RUN: begin
                    if (flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (cnt == '0) begin
                        hi    <= product_c[PROD_W-1:WIDTH];
                        lo    <= product_c[WIDTH-1:0];
                        done  <= 1'b1;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                DIV_RUN: begin
                    if (flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (cnt == '0) begin
                        // Final edge: all quotient bits are in, apply signs and write back
                        if (!dbz_pend_q) begin
                            hi <= rem_fix_c;
                            lo <= quo_fix_c;
                        end
                        done        <= 1'b1;
                        div_by_zero <= dbz_pend_q;
                        state       <= IDLE;
                        busy        <= 1'b0;
                    end else begin
                        rem_q <= rem_next_c;
                        a_q   <= {a_q[WIDTH-2:0], fits_c};
                        cnt   <= cnt - CNT_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
